// File: rtl/agu_pipe.sv
// Pipelined segment:offset address generation unit with string-burst mode (op 6).
// Optional overflow flag output enabled by defining AGU_OVF_FLAG_EN.
module agu_pipe #(
    parameter int unsigned OFF_W     = 16,
    parameter int unsigned SEG_SHIFT = 4,
    parameter int unsigned ADDR_W    = 20,
    parameter int unsigned CNT_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        op,
    input  logic [OFF_W-1:0]  relative,
    input  logic [OFF_W-1:0]  data_segment,
    input  logic [OFF_W-1:0]  data_ip,
    input  logic [OFF_W-1:0]  data_reg1,
    input  logic [OFF_W-1:0]  data_reg2,
    input  logic [CNT_W-1:0]  burst_len,
    input  logic              dir,
    input  logic              size,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] direction,
    output logic              out_last,
    output logic              busy
`ifdef AGU_OVF_FLAG_EN
    ,
    output logic              ovf
`endif
);

    localparam logic [2:0] OpBurst = 3'd6;

`ifdef AGU_OVF_FLAG_EN
    // Two extra bits hold the carries of a three-operand offset sum.
    localparam int unsigned OS_W = OFF_W + 2;
    localparam int unsigned SEG_W = OFF_W + SEG_SHIFT;
    localparam int unsigned PS_W = ((SEG_W > ADDR_W) ? SEG_W : ADDR_W) + 1;
`else
    localparam int unsigned OS_W = OFF_W;
    localparam int unsigned PS_W = ADDR_W;
`endif

    typedef enum logic [0:0] {StIdle, StBurst} state_e;

    state_e             state_q;
    logic               s1_valid_q;
    logic [OFF_W-1:0]   s1_seg_q;
    logic [OFF_W-1:0]   s1_off_q;
    logic               s1_last_q;
    logic [OFF_W-1:0]   b_seg_q;
    logic [OFF_W-1:0]   ptr_q;
    logic [CNT_W-1:0]   rem_q;
    logic               b_dec_q;
    logic               b_word_q;

    logic               out_adv;
    logic               s1_adv;
    logic               accept;
    logic               b_final;
    logic [OFF_W-1:0]   step;
    logic [OFF_W-1:0]   ptr_next;
    logic [OS_W-1:0]    off_sum;
    logic [PS_W-1:0]    phys_sum;

    // Each stage loads when empty or when its downstream stage is advancing.
    assign out_adv  = !out_valid || out_ready;
    assign s1_adv   = !s1_valid_q || out_adv;
    assign in_ready = !rst && (state_q == StIdle) && s1_adv;
    assign accept   = in_valid && in_ready;
    assign busy     = (state_q == StBurst) || s1_valid_q || out_valid;

    assign b_final  = (rem_q == CNT_W'(1));
    assign step     = b_word_q ? OFF_W'(2) : OFF_W'(1);
    assign ptr_next = b_dec_q ? (ptr_q - step) : (ptr_q + step);

    always_comb begin
        off_sum = '0;
        unique case (op)
            3'd0:    off_sum = OS_W'(data_ip);
            3'd1:    off_sum = OS_W'(relative);
            3'd2:    off_sum = OS_W'(data_reg1);
            3'd3:    off_sum = OS_W'(data_reg1) + OS_W'(relative);
            3'd4:    off_sum = OS_W'(data_reg1) + OS_W'(data_reg2);
            3'd5:    off_sum = OS_W'(data_reg1) + OS_W'(data_reg2) + OS_W'(relative);
            3'd6:    off_sum = '0;
            default: off_sum = OS_W'(data_reg1);
        endcase
    end

    // Wide enough to expose the carry out of ADDR_W when the flag is built in.
    assign phys_sum = (PS_W'(s1_seg_q) << SEG_SHIFT) + PS_W'(s1_off_q);

`ifdef AGU_OVF_FLAG_EN
    logic s1_ocarry_q;
`endif

    // Burst FSM and stage 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            s1_valid_q <= 1'b0;
            s1_seg_q   <= '0;
            s1_off_q   <= '0;
            s1_last_q  <= 1'b0;
            b_seg_q    <= '0;
            ptr_q      <= '0;
            rem_q      <= '0;
            b_dec_q    <= 1'b0;
            b_word_q   <= 1'b0;
`ifdef AGU_OVF_FLAG_EN
            s1_ocarry_q <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept && (op == OpBurst)) begin
                        b_seg_q  <= data_segment;
                        ptr_q    <= data_reg1;
                        rem_q    <= (burst_len == '0) ? CNT_W'(1) : burst_len;
                        b_dec_q  <= dir;
                        b_word_q <= size;
                        state_q  <= StBurst;
                    end
                end
                StBurst: begin
                    if (s1_adv) begin
                        ptr_q <= ptr_next;
                        rem_q <= rem_q - CNT_W'(1);
                        if (b_final) begin
                            state_q <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase

            if (s1_adv) begin
                if (state_q == StBurst) begin
                    s1_valid_q <= 1'b1;
                    s1_seg_q   <= b_seg_q;
                    s1_off_q   <= ptr_q;
                    s1_last_q  <= b_final;
`ifdef AGU_OVF_FLAG_EN
                    s1_ocarry_q <= 1'b0;
`endif
                end else if (accept && (op != OpBurst)) begin
                    s1_valid_q <= 1'b1;
                    s1_seg_q   <= data_segment;
                    s1_off_q   <= off_sum[OFF_W-1:0];
                    s1_last_q  <= 1'b1;
`ifdef AGU_OVF_FLAG_EN
                    s1_ocarry_q <= |off_sum[OS_W-1:OFF_W];
`endif
                end else begin
                    s1_valid_q <= 1'b0;
                end
            end
        end
    end

    // Stage 2: output register, held while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            direction <= '0;
            out_last  <= 1'b0;
`ifdef AGU_OVF_FLAG_EN
            ovf       <= 1'b0;
`endif
        end else if (out_adv) begin
            out_valid <= s1_valid_q;
            if (s1_valid_q) begin
                direction <= phys_sum[ADDR_W-1:0];
                out_last  <= s1_last_q;
`ifdef AGU_OVF_FLAG_EN
                ovf       <= s1_ocarry_q || (|phys_sum[PS_W-1:ADDR_W]);
`endif
            end
        end
    end

endmodule

// File: tb/tb_agu_pipe.sv
// Self-checking bench for agu_pipe: directed cases plus randomized traffic
// scored against an in-order queue of expected addresses.
module tb_agu_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [15:0] relative, data_segment, data_ip, data_reg1, data_reg2;
    logic [7:0]  burst_len;
    logic        dir, size;
    logic        out_valid;
    logic        out_ready;
    logic [19:0] direction;
    logic        out_last;
    logic        busy;
`ifdef AGU_OVF_FLAG_EN
    logic        ovf;
`endif

    agu_pipe dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .op           (op),
        .relative     (relative),
        .data_segment (data_segment),
        .data_ip      (data_ip),
        .data_reg1    (data_reg1),
        .data_reg2    (data_reg2),
        .burst_len    (burst_len),
        .dir          (dir),
        .size         (size),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .direction    (direction),
        .out_last     (out_last),
        .busy         (busy)
`ifdef AGU_OVF_FLAG_EN
        ,
        .ovf          (ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [19:0] addr;
        logic        last;
        logic        ovf;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_out = 0;
    bit   rnd_done = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: every accepted request expands to its list of output beats.
    task automatic push_req(input logic [2:0] o, input logic [15:0] sg, ip, rel, r1, r2,
                            input logic [7:0] len, input logic d, sz);
        int unsigned raw, off, phys, n, stp;
        exp_t e;
        if (o == 3'd6) begin
            n   = (len == 0) ? 1 : int'(len);
            stp = sz ? 2 : 1;
            for (int unsigned i = 0; i < n; i++) begin
                if (d) off = (32'(r1) + 32'h40000 - i * stp) & 32'hFFFF;
                else   off = (32'(r1) + i * stp) & 32'hFFFF;
                phys   = 32'(sg) * 16 + off;
                e.addr = phys[19:0];
                e.last = (i == n - 1);
                e.ovf  = (phys > 32'hFFFFF);
                exp_q.push_back(e);
            end
        end else begin
            case (o)
                3'd0:    raw = 32'(ip);
                3'd1:    raw = 32'(rel);
                3'd3:    raw = 32'(r1) + 32'(rel);
                3'd4:    raw = 32'(r1) + 32'(r2);
                3'd5:    raw = 32'(r1) + 32'(r2) + 32'(rel);
                default: raw = 32'(r1);
            endcase
            off    = raw & 32'hFFFF;
            phys   = 32'(sg) * 16 + off;
            e.addr = phys[19:0];
            e.last = 1'b1;
            e.ovf  = (raw > 32'hFFFF) || (phys > 32'hFFFFF);
            exp_q.push_back(e);
        end
    endtask

    // Inputs change just after posedge, so negedge sees the upcoming handshakes.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 32'(direction), 32'hFFFFFFFF);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("addr", 32'(direction), 32'(mon_e.addr));
                    check("last", 32'(out_last), 32'(mon_e.last));
`ifdef AGU_OVF_FLAG_EN
                    check("ovf", 32'(ovf), 32'(mon_e.ovf));
`endif
                end
            end
            if (in_valid && in_ready) begin
                push_req(op, data_segment, data_ip, relative, data_reg1, data_reg2,
                         burst_len, dir, size);
            end
        end
    end

    // Called just after a posedge; returns just after the accepting posedge.
    task automatic send(input logic [2:0] o, input logic [15:0] sg, ip, rel, r1, r2,
                        input logic [7:0] len, input logic d, sz);
        int t = 0;
        op = o; data_segment = sg; data_ip = ip; relative = rel;
        data_reg1 = r1; data_reg2 = r2; burst_len = len; dir = d; size = sz;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 1000) check("accept_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        out_ready = 1'b1;
        while ((exp_q.size() != 0 || busy) && t < 500) begin
            @(posedge clk);
            t++;
        end
        #1;
        check("drain_queue", 32'(exp_q.size()), 32'd0);
        check("drain_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int base, t;
        logic [19:0] hold;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        op = '0; relative = '0; data_segment = '0; data_ip = '0;
        data_reg1 = '0; data_reg2 = '0; burst_len = '0; dir = 1'b0; size = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_direction", 32'(direction), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1 check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // op0: two-cycle latency
        send(3'd0, 16'h1000, 16'h0234, 16'h5555, 16'h1111, 16'h2222, 8'd0, 1'b0, 1'b0);
        check("lat_stage1", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check("lat_valid", 32'(out_valid), 32'd1);
        check("op0_addr", 32'(direction), 32'h10234);
        check("op0_last", 32'(out_last), 32'd1);
        drain();

        // op5: offset wraps
        send(3'd5, 16'h2000, 16'h0000, 16'h0001, 16'hFFF0, 16'h0020, 8'd0, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("op5_addr", 32'(direction), 32'h20011);
`ifdef AGU_OVF_FLAG_EN
        check("op5_ovf", 32'(ovf), 32'd1);
`endif
        drain();

        // op1: physical address wraps
        send(3'd1, 16'hFFFF, 16'h0000, 16'h0010, 16'h0000, 16'h0000, 8'd0, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("op1_addr", 32'(direction), 32'h00000);
`ifdef AGU_OVF_FLAG_EN
        check("op1_ovf", 32'(ovf), 32'd1);
`endif
        drain();

        // op6: decrementing word burst of 3
        send(3'd6, 16'h3000, 16'h0000, 16'h0000, 16'h0010, 16'h0000, 8'd3, 1'b1, 1'b1);
        @(posedge clk); #1;
        check("burst_in_ready1", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        check("burst_in_ready2", 32'(in_ready), 32'd0);
        check("burst_a0", 32'(direction), 32'h30010);
        check("burst_l0", 32'(out_last), 32'd0);
        @(posedge clk); #1;
        check("burst_in_ready3", 32'(in_ready), 32'd1);
        check("burst_a1", 32'(direction), 32'h3000E);
        check("burst_l1", 32'(out_last), 32'd0);
        @(posedge clk); #1;
        check("burst_a2", 32'(direction), 32'h3000C);
        check("burst_l2", 32'(out_last), 32'd1);
        drain();

        // Backpressure mid-stream of op2 requests
        fork
            begin
                for (int k = 0; k < 6; k++)
                    send(3'd2, 16'h0100, 16'h0, 16'h0, 16'h0100 + 16'(k), 16'h0, 8'd0, 1'b0, 1'b0);
            end
            begin
                repeat (3) @(posedge clk);
                #2 out_ready = 1'b0;
                hold = direction;
                check("bp_valid", 32'(out_valid), 32'd1);
                repeat (3) begin
                    @(posedge clk); #2;
                    check("bp_hold", 32'(direction), 32'(hold));
                    check("bp_valid_held", 32'(out_valid), 32'd1);
                end
                check("bp_in_ready", 32'(in_ready), 32'd0);
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset during a 5-beat burst
        base = n_out;
        send(3'd6, 16'h4000, 16'h0, 16'h0, 16'h0100, 16'h0, 8'd5, 1'b0, 1'b0);
        t = 0;
        while (n_out < base + 2 && t < 100) begin
            @(posedge clk);
            t++;
        end
        check("rst_burst_beats", 32'(n_out - base), 32'd2);
        #1 rst = 1'b1;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        send(3'd0, 16'h0500, 16'h0007, 16'h0, 16'h0, 16'h0, 8'd0, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("after_rst_addr", 32'(direction), 32'h05007);
        check("after_rst_valid", 32'(out_valid), 32'd1);
        drain();

        // Randomized traffic with random backpressure
        fork
            begin
                for (int k = 0; k < 200; k++) begin
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    #1;
                    send(3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom),
                         16'($urandom), 16'($urandom), 16'($urandom),
                         8'($urandom_range(0, 6)), 1'($urandom), 1'($urandom));
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #2 out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
